// File: rtl/legv8_ctrl_seq_if.sv
// Instruction handshake between the upstream instruction source and legv8_ctrl_seq.
// A word moves only on a rising edge where instr_valid and instr_ready are both high.
// The source must hold instr stable while instr_valid is high and instr_ready is low.
interface legv8_ctrl_seq_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/legv8_ctrl_seq.sv
// Multi-cycle LEGv8 R/I-type control sequencer driving the alu_reg control word.
// The macro LEGV8_FLAG_SET_EN enables ADDS/SUBS decoding and the NZCV flags register.
module legv8_ctrl_seq #(
  parameter int XZR_IDX = 31,
  parameter int KW      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  legv8_ctrl_seq_if.slave      up,
  input  logic [3:0]           status,
  output logic [4:0]           fs,
  output logic [4:0]           addrA,
  output logic [4:0]           addrB,
  output logic [4:0]           addrR,
  output logic [KW-1:0]        k,
  output logic                 s,
  output logic                 c0,
  output logic                 w,
  output logic                 busy,
  output logic                 illegal,
  output logic [3:0]           flags,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] WB     = 2'd3;
  localparam logic [4:0] XZR    = 5'(XZR_IDX);

  logic [1:0]    state;
  logic [31:0]   ir;
  logic          d_legal;
  logic [4:0]    d_fs;
  logic [4:0]    d_b;
  logic [KW-1:0] d_k;
  logic          d_s;
  logic          d_c0;
`ifdef LEGV8_FLAG_SET_EN
  logic          d_upd;
`endif

  assign up.instr_ready = (state == IDLE);
  assign busy           = (state != IDLE);
  assign dbg_state      = state;

  // R-type opcodes are tried first; I-type only decodes when no R-type matches.
  always_comb begin
    d_legal = 1'b0;
    d_fs    = 5'b0;
    d_b     = 5'b0;
    d_k     = '0;
    d_s     = 1'b0;
    d_c0    = 1'b0;
`ifdef LEGV8_FLAG_SET_EN
    d_upd   = 1'b0;
`endif
    case (ir[31:21])
      11'b10001011000: begin d_legal = 1'b1; d_fs = 5'b01000; d_b = ir[20:16]; end
      11'b11001011000: begin d_legal = 1'b1; d_fs = 5'b01001; d_b = ir[20:16]; d_c0 = 1'b1; end
      11'b10001010000: begin d_legal = 1'b1; d_fs = 5'b00000; d_b = ir[20:16]; end
      11'b10101010000: begin d_legal = 1'b1; d_fs = 5'b00100; d_b = ir[20:16]; end
      11'b11001010000: begin d_legal = 1'b1; d_fs = 5'b01100; d_b = ir[20:16]; end
      11'b11010011011: begin
        d_legal = 1'b1; d_fs = 5'b10000; d_b = ir[20:16]; d_s = 1'b1;
        d_k = {{(KW-6){1'b0}}, ir[15:10]};
      end
      11'b11010011010: begin
        d_legal = 1'b1; d_fs = 5'b10100; d_b = ir[20:16]; d_s = 1'b1;
        d_k = {{(KW-6){1'b0}}, ir[15:10]};
      end
`ifdef LEGV8_FLAG_SET_EN
      11'b10101011000: begin d_legal = 1'b1; d_fs = 5'b01000; d_b = ir[20:16]; d_upd = 1'b1; end
      11'b11101011000: begin
        d_legal = 1'b1; d_fs = 5'b01001; d_b = ir[20:16]; d_c0 = 1'b1; d_upd = 1'b1;
      end
`endif
      default: begin
        case (ir[31:22])
          10'b1001000100: begin d_legal = 1'b1; d_fs = 5'b01000; end
          10'b1101000100: begin d_legal = 1'b1; d_fs = 5'b01001; d_c0 = 1'b1; end
          10'b1001001000: begin d_legal = 1'b1; d_fs = 5'b00000; end
          10'b1011001000: begin d_legal = 1'b1; d_fs = 5'b00100; end
          10'b1101001000: begin d_legal = 1'b1; d_fs = 5'b01100; end
          default: ;
        endcase
        if (d_legal) begin
          d_s = 1'b1;
          d_k = {{(KW-12){1'b0}}, ir[21:10]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ir      <= 32'b0;
      fs      <= 5'b0;
      addrA   <= 5'b0;
      addrB   <= 5'b0;
      addrR   <= 5'b0;
      k       <= '0;
      s       <= 1'b0;
      c0      <= 1'b0;
      w       <= 1'b0;
      illegal <= 1'b0;
    end else begin
      w       <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (up.instr_valid) begin
            ir    <= up.instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (d_legal) begin
            fs    <= d_fs;
            addrA <= ir[9:5];
            addrB <= d_b;
            addrR <= ir[4:0];
            k     <= d_k;
            s     <= d_s;
            c0    <= d_c0;
            state <= EXEC;
          end else begin
            illegal <= 1'b1;
            state   <= IDLE;
          end
        end
        EXEC: begin
          // A write to the zero register is dropped; the walk through WB still happens.
          w     <= (addrR != XZR);
          state <= WB;
        end
        default: begin
          fs    <= 5'b0;
          addrA <= 5'b0;
          addrB <= 5'b0;
          addrR <= 5'b0;
          k     <= '0;
          s     <= 1'b0;
          c0    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LEGV8_FLAG_SET_EN
  logic       upd_q;
  logic [3:0] flags_q;

  // Flags load on the WB exit edge, the same edge alu_reg commits the w write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_q   <= 1'b0;
      flags_q <= 4'b0;
    end else begin
      if (state == DECODE && d_legal) upd_q <= d_upd;
      if (state == WB && upd_q) flags_q <= status;
    end
  end
  assign flags = flags_q;
`else
  logic unused_status;
  assign unused_status = ^status;
  assign flags = 4'b0;
`endif

endmodule

// File: tb/tb_legv8_ctrl_seq.sv
// Directed table-driven bench for legv8_ctrl_seq: per-cycle control word, w/illegal pulses,
// flags, held-valid handshake and asynchronous reset mid-operation.
module tb_legv8_ctrl_seq;

`ifdef LEGV8_FLAG_SET_EN
  localparam bit flag_en = 1'b1;
`else
  localparam bit flag_en = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  status;
    logic [4:0]  fs;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  r;
    logic [63:0] k;
    logic        s;
    logic        c0;
    logic        w;
    logic        ill;
    logic        upd;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  status;
  logic [4:0]  fs, addrA, addrB, addrR;
  logic [63:0] k;
  logic        s, c0, w, busy, illegal;
  logic [3:0]  flags;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_flags = 4'b0;
  vec_t tbl[$];

  legv8_ctrl_seq_if bus();

  legv8_ctrl_seq #(.XZR_IDX(31), .KW(64)) dut (
    .clk(clk), .rst(rst), .up(bus), .status(status),
    .fs(fs), .addrA(addrA), .addrB(addrB), .addrR(addrR), .k(k),
    .s(s), .c0(c0), .w(w), .busy(busy), .illegal(illegal),
    .flags(flags), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] r_enc(input logic [10:0] op, input int rm, input int sh,
                                        input int rn, input int rd);
    r_enc = {op, 5'(rm), 6'(sh), 5'(rn), 5'(rd)};
  endfunction

  function automatic logic [31:0] i_enc(input logic [9:0] op, input int imm, input int rn,
                                        input int rd);
    i_enc = {op, 12'(imm), 5'(rn), 5'(rd)};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] st, input logic [4:0] f,
                              input int a, input int b, input int r, input int kk,
                              input logic ss, input logic cc, input logic ww, input logic uu);
    vec_t v;
    v.instr = instr; v.status = st; v.fs = f;
    v.a = 5'(a); v.b = 5'(b); v.r = 5'(r); v.k = 64'(kk);
    v.s = ss; v.c0 = cc; v.w = ww; v.ill = 1'b0; v.upd = uu;
    return v;
  endfunction

  function automatic vec_t mk_ill(input logic [31:0] instr, input logic [3:0] st);
    vec_t v;
    v = mk(instr, st, 5'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    v.ill = 1'b1;
    return v;
  endfunction

  // scoreboard
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input vec_t v, input bit zero);
    chk({tag, ".fs"},    fs,    zero ? 64'd0 : 64'(v.fs));
    chk({tag, ".addrA"}, addrA, zero ? 64'd0 : 64'(v.a));
    chk({tag, ".addrB"}, addrB, zero ? 64'd0 : 64'(v.b));
    chk({tag, ".addrR"}, addrR, zero ? 64'd0 : 64'(v.r));
    chk({tag, ".k"},     k,     zero ? 64'd0 : v.k);
    chk({tag, ".s"},     s,     zero ? 64'd0 : 64'(v.s));
    chk({tag, ".c0"},    c0,    zero ? 64'd0 : 64'(v.c0));
  endtask

  // driver tasks
  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".ready_wait"}, 64'(bus.instr_ready), 64'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    wait_ready(tag);
    bus.instr = v.instr; bus.instr_valid = 1'b1; status = v.status;
    @(negedge clk);
    bus.instr_valid = 1'b0; bus.instr = $urandom;
    chk({tag, ".dec_state"}, dbg_state, 64'd1);
    chk({tag, ".dec_busy"},  busy, 64'd1);
    chk({tag, ".dec_ready"}, bus.instr_ready, 64'd0);
    chk({tag, ".dec_w"},     w, 64'd0);
    chk_ctrl({tag, ".dec"}, v, 1'b1);
    @(negedge clk);
    if (v.ill) begin
      chk({tag, ".ill_pulse"}, illegal, 64'd1);
      chk({tag, ".ill_state"}, dbg_state, 64'd0);
      chk({tag, ".ill_w"},     w, 64'd0);
      chk({tag, ".ill_flags"}, flags, 64'(exp_flags));
      chk_ctrl({tag, ".ill"}, v, 1'b1);
      @(negedge clk);
      chk({tag, ".ill_end"}, illegal, 64'd0);
    end else begin
      chk({tag, ".ex_state"}, dbg_state, 64'd2);
      chk({tag, ".ex_w"},     w, 64'd0);
      chk({tag, ".ex_ill"},   illegal, 64'd0);
      chk_ctrl({tag, ".ex"}, v, 1'b0);
      @(negedge clk);
      chk({tag, ".wb_state"}, dbg_state, 64'd3);
      chk({tag, ".wb_w"},     w, 64'(v.w));
      chk({tag, ".wb_flags"}, flags, 64'(exp_flags));
      chk_ctrl({tag, ".wb"}, v, 1'b0);
      if (v.upd) exp_flags = v.status;
      @(negedge clk);
      chk({tag, ".end_state"}, dbg_state, 64'd0);
      chk({tag, ".end_busy"},  busy, 64'd0);
      chk({tag, ".end_w"},     w, 64'd0);
      chk({tag, ".end_flags"}, flags, 64'(exp_flags));
      chk_ctrl({tag, ".end"}, v, 1'b1);
    end
  endtask

  initial begin
    vec_t zv;
    vec_t va;
    int wcnt;
    zv = mk(32'h0, 4'h0, 5'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; bus.instr = 32'h0; bus.instr_valid = 1'b0; status = 4'h0;

    tbl.push_back(mk(32'h8B1402E0, 4'h0, 5'b01000, 23, 20, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(i_enc(10'b1001000100, 3, 21, 1), 4'h0, 5'b01000, 21, 0, 1, 3, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(32'hCB1702C3, 4'h0, 5'b01001, 22, 23, 3, 0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(r_enc(11'b11010011011, 0, 2, 20, 5), 4'h0, 5'b10000, 20, 0, 5, 2, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(r_enc(11'b11010011010, 0, 63, 7, 6), 4'h0, 5'b10100, 7, 0, 6, 63, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(r_enc(11'b10001010000, 10, 3, 9, 8), 4'h0, 5'b00000, 9, 10, 8, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(r_enc(11'b10101010000, 13, 0, 12, 11), 4'h0, 5'b00100, 12, 13, 11, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(r_enc(11'b11001010000, 16, 0, 15, 14), 4'h0, 5'b01100, 15, 16, 14, 0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(i_enc(10'b1101000100, 4095, 18, 17), 4'h0, 5'b01001, 18, 0, 17, 4095, 1'b1, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(i_enc(10'b1001001000, 240, 2, 19), 4'h0, 5'b00000, 2, 0, 19, 240, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(i_enc(10'b1011001000, 1, 3, 20), 4'h0, 5'b00100, 3, 0, 20, 1, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(i_enc(10'b1101001000, 2748, 4, 21), 4'h0, 5'b01100, 4, 0, 21, 2748, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(r_enc(11'b10001011000, 2, 0, 1, 31), 4'h0, 5'b01000, 1, 2, 31, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk_ill(32'hFFFFFFFF, 4'h0));
    if (flag_en) begin
      tbl.push_back(mk(r_enc(11'b11101011000, 21, 0, 21, 4), 4'b0001, 5'b01001, 21, 21, 4, 0, 1'b0, 1'b1, 1'b1, 1'b1));
      tbl.push_back(mk(r_enc(11'b10101011000, 1, 0, 1, 31), 4'b1010, 5'b01000, 1, 1, 31, 0, 1'b0, 1'b0, 1'b0, 1'b1));
    end else begin
      tbl.push_back(mk_ill(r_enc(11'b11101011000, 21, 0, 21, 4), 4'b0001));
      tbl.push_back(mk_ill(r_enc(11'b10101011000, 1, 0, 1, 31), 4'b1010));
    end
    tbl.push_back(mk(r_enc(11'b10001011000, 1, 0, 1, 1), 4'b1111, 5'b01000, 1, 1, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0));

    // reset state while rst is held low
    #2;
    chk("rst.state", dbg_state, 64'd0);
    chk("rst.ready", bus.instr_ready, 64'd1);
    chk("rst.busy",  busy, 64'd0);
    chk("rst.w",     w, 64'd0);
    chk("rst.illegal", illegal, 64'd0);
    chk("rst.flags", flags, 64'd0);
    chk_ctrl("rst", zv, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // instr_valid held through busy: second word accepted exactly once, after IDLE
    wait_ready("hold");
    bus.instr = r_enc(11'b10001011000, 3, 0, 2, 1); bus.instr_valid = 1'b1; status = 4'h0;
    @(negedge clk);
    bus.instr = r_enc(11'b10101010000, 11, 0, 10, 9);
    chk("hold.dec_ready", bus.instr_ready, 64'd0);
    @(negedge clk);
    chk("hold.ex_state", dbg_state, 64'd2);
    @(negedge clk);
    chk("hold.wb_w", w, 64'd1);
    chk("hold.wb_r", addrR, 64'd1);
    @(negedge clk);
    chk("hold.idle_state", dbg_state, 64'd0);
    chk("hold.idle_ready", bus.instr_ready, 64'd1);
    @(negedge clk);
    chk("hold.b_dec", dbg_state, 64'd1);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("hold.b_r",  addrR, 64'd9);
    chk("hold.b_fs", fs, 64'b00100);
    chk("hold.b_a",  addrA, 64'd10);
    @(negedge clk);
    chk("hold.b_w", w, 64'd1);
    @(negedge clk);
    chk("hold.b_idle", dbg_state, 64'd0);
    @(negedge clk);
    chk("hold.no_reaccept", dbg_state, 64'd0);

    // asynchronous reset in EXEC of an ADD: abort, no write, flags back to 0
    va = mk(r_enc(11'b10001011000, 5, 0, 6, 7), 4'b0101, 5'b01000, 6, 5, 7, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_ready("rstx");
    bus.instr = va.instr; bus.instr_valid = 1'b1; status = va.status;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("rstx.ex_state", dbg_state, 64'd2);
    chk("rstx.ex_r", addrR, 64'd7);
    rst = 1'b0;
    #1;
    chk("rstx.state", dbg_state, 64'd0);
    chk("rstx.ready", bus.instr_ready, 64'd1);
    chk("rstx.busy",  busy, 64'd0);
    chk("rstx.w",     w, 64'd0);
    chk("rstx.flags", flags, 64'd0);
    chk_ctrl("rstx", va, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    wcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (w === 1'b1) wcnt++;
    end
    chk("rstx.no_w", 64'(wcnt), 64'd0);
    chk("rstx.idle_after", dbg_state, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
